// File: rtl/rr_arbiter_if.sv
// Request/grant bundle for rr_arbiter: requesters drive req, the arbiter drives
// the registered one-hot grant plus its valid flag and binary index.
interface rr_arbiter_if #(
  parameter int unsigned N = 24
);
  localparam int unsigned W = $clog2(N);

  logic [N-1:0] req;
  logic [N-1:0] grant;
  logic         grant_valid;
  logic [W-1:0] grant_idx;

  modport master (output req, input grant, input grant_valid, input grant_idx);
  modport slave  (input req, output grant, output grant_valid, output grant_idx);
endinterface

// File: rtl/rr_arbiter.sv
// Registered round-robin arbiter with grant locking; define RR_ARBITER_TIMEOUT_EN
// to force rotation after MAX_HOLD consecutive grant cycles when others are waiting.
module rr_arbiter #(
  parameter int unsigned N        = 24,
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic        clk,
  input  logic        rst,
  rr_arbiter_if.slave bus
);
  localparam int unsigned W = $clog2(N);

  if (N < 2 || N > 32 || MAX_HOLD < 2 || MAX_HOLD > 65535) begin : g_param_check
    $error("rr_arbiter: N must be 2..32 and MAX_HOLD 2..65535");
  end

  typedef enum logic {IDLE, BUSY} state_t;

  state_t       state_q, state_d;
  logic [N-1:0] grant_q, grant_d;
  logic         valid_q, valid_d;
  logic [W-1:0] idx_q, idx_d;
  logic [W-1:0] ptr_q, ptr_d;

`ifdef RR_ARBITER_TIMEOUT_EN
  localparam logic [15:0] HOLD_LAST = 16'(MAX_HOLD - 1);
  logic [15:0] hcnt_q, hcnt_d;
`endif

  // grant_q is zero in IDLE and one-hot in BUSY, so masking it out removes
  // exactly the current holder from the search.
  logic [N-1:0] elig;
  logic         cand_found;
  logic [W-1:0] cand_idx;
  int unsigned  pos;
  logic [W-1:0] pos_w;

  assign elig = bus.req & ~grant_q;

  // Scan ptr+1 .. ptr wrapping modulo N (not 2^W), first eligible bit wins.
  always_comb begin
    cand_found = 1'b0;
    cand_idx   = '0;
    pos        = 0;
    pos_w      = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      pos = 32'(ptr_q) + i;
      if (pos >= N) pos = pos - N;
      pos_w = pos[W-1:0];
      if (!cand_found && elig[pos_w]) begin
        cand_found = 1'b1;
        cand_idx   = pos_w;
      end
    end
  end

  always_comb begin
    logic take;
    logic drop;
    take    = 1'b0;
    drop    = 1'b0;
    state_d = state_q;
    grant_d = grant_q;
    valid_d = valid_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
`ifdef RR_ARBITER_TIMEOUT_EN
    hcnt_d  = hcnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (cand_found) take = 1'b1;
      end
      BUSY: begin
        if (bus.req[idx_q]) begin
`ifdef RR_ARBITER_TIMEOUT_EN
          if (hcnt_q == HOLD_LAST && cand_found) begin
            take = 1'b1;
          end else if (hcnt_q != HOLD_LAST) begin
            hcnt_d = hcnt_q + 16'd1;
          end
`endif
        end else if (cand_found) begin
          take = 1'b1;
        end else begin
          drop = 1'b1;
        end
      end
      default: drop = 1'b1;
    endcase

    if (take) begin
      state_d = BUSY;
      grant_d = N'(1) << cand_idx;
      valid_d = 1'b1;
      idx_d   = cand_idx;
      ptr_d   = cand_idx;
`ifdef RR_ARBITER_TIMEOUT_EN
      hcnt_d  = '0;
`endif
    end else if (drop) begin
      state_d = IDLE;
      grant_d = '0;
      valid_d = 1'b0;
      idx_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      valid_q <= 1'b0;
      idx_q   <= '0;
      ptr_q   <= W'(N - 1);
`ifdef RR_ARBITER_TIMEOUT_EN
      hcnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
`ifdef RR_ARBITER_TIMEOUT_EN
      hcnt_q  <= hcnt_d;
`endif
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_valid = valid_q;
  assign bus.grant_idx   = idx_q;
endmodule

// File: tb/tb_rr_arbiter.sv
// Scoreboard bench for rr_arbiter at N=4, MAX_HOLD=4; expectations adapt to
// whether RR_ARBITER_TIMEOUT_EN is defined for the build.
module tb_rr_arbiter;
  localparam int unsigned N        = 4;
  localparam int unsigned MAX_HOLD = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  rr_arbiter_if #(.N(N)) bus ();

  rr_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Packed observation: {grant[3:0], grant_valid, grant_idx[1:0]}
  logic [6:0] sb[$];
  logic [6:0] exp_v, got_v;
  int n_cmp  = 0;
  int n_fail = 0;

  function automatic logic [6:0] pack_exp(input bit v, input int unsigned idx);
    logic [3:0] g;
    if (!v) return '0;
    g = 4'(1 << idx);
    return {g, 1'b1, 2'(idx)};
  endfunction

  task automatic apply_reset();
    rst     = 1'b1;
    bus.req = '0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst     = 1'b1;
    bus.req = 4'b1111;
    for (int i = 0; i < 2; i++) begin
      sb.push_back(pack_exp(0, 0));
      @(posedge clk); #1;
      exp_v = sb.pop_front();
      got_v = {bus.grant, bus.grant_valid, bus.grant_idx};
      n_cmp++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL reset cyc%0d: got %b expected %b", i, got_v, exp_v);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_rotation();
    int unsigned seq[5] = '{0, 1, 2, 3, 0};
    logic [3:0] cur;
    apply_reset();
    cur = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      bus.req = 4'b1111 & ~cur;
      sb.push_back(pack_exp(1, seq[i]));
      @(posedge clk); #1;
      exp_v = sb.pop_front();
      got_v = {bus.grant, bus.grant_valid, bus.grant_idx};
      n_cmp++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL rotation step%0d: got %b expected %b", i, got_v, exp_v);
      end
      cur = 4'(1 << seq[i]);
    end
  endtask

  task automatic test_hold_release();
    apply_reset();
    for (int i = 0; i < 12; i++) begin
      bus.req = (i < 10) ? 4'b0100 : 4'b0000;
      sb.push_back((i < 10) ? pack_exp(1, 2) : pack_exp(0, 0));
      @(posedge clk); #1;
      exp_v = sb.pop_front();
      got_v = {bus.grant, bus.grant_valid, bus.grant_idx};
      n_cmp++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL hold_release cyc%0d: got %b expected %b", i, got_v, exp_v);
      end
    end
  endtask

  task automatic test_wrap();
    logic [3:0] reqs[3] = '{4'b1000, 4'b1011, 4'b0011};
    int unsigned exps[3] = '{3, 3, 0};
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      bus.req = reqs[i];
      sb.push_back(pack_exp(1, exps[i]));
      @(posedge clk); #1;
      exp_v = sb.pop_front();
      got_v = {bus.grant, bus.grant_valid, bus.grant_idx};
      n_cmp++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL wrap step%0d: got %b expected %b", i, got_v, exp_v);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [3:0] reqs[4] = '{4'b0100, 4'b1111, 4'b1111, 4'b1111};
    bit         rsts[4] = '{0, 0, 1, 0};
    logic [6:0] exps[4];
    exps[0] = pack_exp(1, 2);
    exps[1] = pack_exp(1, 2);
    exps[2] = pack_exp(0, 0);
    exps[3] = pack_exp(1, 0);
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      bus.req = reqs[i];
      rst     = rsts[i];
      sb.push_back(exps[i]);
      @(posedge clk); #1;
      exp_v = sb.pop_front();
      got_v = {bus.grant, bus.grant_valid, bus.grant_idx};
      n_cmp++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL mid_reset step%0d: got %b expected %b", i, got_v, exp_v);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_timeout_pair();
    int unsigned e;
    apply_reset();
    bus.req = 4'b0011;
    for (int i = 0; i < 12; i++) begin
`ifdef RR_ARBITER_TIMEOUT_EN
      e = (i / MAX_HOLD) % 2;
`else
      e = 0;
`endif
      sb.push_back(pack_exp(1, e));
      @(posedge clk); #1;
      exp_v = sb.pop_front();
      got_v = {bus.grant, bus.grant_valid, bus.grant_idx};
      n_cmp++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL timeout_pair cyc%0d: got %b expected %b", i, got_v, exp_v);
      end
    end
  endtask

  task automatic test_single_hold();
    int unsigned e;
    apply_reset();
    for (int i = 0; i < 21; i++) begin
      // After 20 solo cycles the hold count is saturated, so a newcomer
      // takes over at the very next edge when the timeout is built in.
      bus.req = (i < 20) ? 4'b0001 : 4'b0011;
`ifdef RR_ARBITER_TIMEOUT_EN
      e = (i < 20) ? 0 : 1;
`else
      e = 0;
`endif
      sb.push_back(pack_exp(1, e));
      @(posedge clk); #1;
      exp_v = sb.pop_front();
      got_v = {bus.grant, bus.grant_valid, bus.grant_idx};
      n_cmp++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL single_hold cyc%0d: got %b expected %b", i, got_v, exp_v);
      end
    end
  endtask

  initial begin
    bus.req = '0;
    @(posedge clk); #1;
    test_reset();
    test_rotation();
    test_hold_release();
    test_wrap();
    test_mid_reset();
    test_timeout_pair();
    test_single_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/rr_arbiter.md
# rr_arbiter

Registered, parametrised round-robin arbiter with grant locking. Successor to the combinational fixed-priority arbiter that drives the io board DIP-switch to LED path. Takes N request lines, issues a one-hot registered grant, holds it while the winner keeps requesting, then rotates fairly. Sits between io_dip/io_button-derived requests and io_led in au_top, and is reusable for any shared-resource select.

## Interface
Parameters:
- N, 24, number of request channels; legal range 2..32.
- MAX_HOLD, 16, maximum consecutive grant cycles per channel; used only with the timeout feature; legal range 2..65535.

Ports:
- clk  input  1  system clock, 100 MHz; all logic on rising edge.
- rst  input  1  reset; synchronous, active-high.
- req  input  N  request vector; bit i high = channel i wants the resource; level-sensitive.
- grant  output  N  registered one-hot grant, or all zero.
- grant_valid  output  1  high when grant is non-zero.
- grant_idx  output  $clog2(N)  binary index of the granted channel; 0 when grant_valid low.

## Operation
- State: IDLE, BUSY; priority pointer ptr ($clog2(N) bits); hold counter hcnt (16 bits, timeout build only).
- Reset (rst sampled high): state=IDLE, grant=0, grant_valid=0, grant_idx=0, ptr=N-1, hcnt=0. Channel 0 is therefore first priority after reset.
- Search rule: candidate = first set bit of the eligible set, scanning ptr+1, ptr+2, ... wrapping from N-1 to 0, ending at ptr. Index arithmetic is modulo N, not modulo 2^width. This matters for non-power-of-two N such as 24.
- IDLE:
  - req==0: stay IDLE.
  - Otherwise: grant the candidate over req; go BUSY; ptr <= candidate; hcnt <= 0.
- BUSY, with g = grant_idx:
  - req[g] high: hold the grant; hcnt increments.
  - req[g] low: search over req with bit g masked out.
    - Candidate found: grant it in the same edge (no idle bubble); ptr <= candidate; hcnt <= 0.
    - None found: go IDLE; grant=0.
- Requests from other channels never preempt a held grant, except through the timeout feature.
- Requests that change between edges are ignored; only values sampled at the edge matter.
- rst high in any state, including mid-grant, forces the reset values at that edge regardless of req.
- grant, grant_valid and grant_idx always change together and are mutually consistent.

## Timing
- Grant latency: req sampled at edge k gives grant visible after edge k, one cycle, from IDLE.
- Release handoff: req[g] sampled low at edge k gives the next grant, or zero, after edge k. The old grant is never shown one extra cycle.
- All outputs are flop outputs; there is no combinational path from req to any output.
- Fairness: with all N requesting continuously and each releasing after one cycle, every channel is granted exactly once in any window of N consecutive grants.

## Configuration
- Macro: RR_ARBITER_TIMEOUT_EN.
- Defined:
  - In BUSY, hcnt counts grant cycles.
  - Rotation condition: hcnt == MAX_HOLD-1 while req[g] is still high and any other req bit is high.
  - On that condition, the grant moves to the search over req with bit g masked; ptr updates; hcnt <= 0.
  - If no other channel is requesting, the grant is kept and hcnt saturates at MAX_HOLD-1.
- Undefined: hcnt logic is absent; a channel holds its grant for as long as its req stays high.

## Test plan
Bench uses N=4 and MAX_HOLD=4.
- Reset then req=4'b1111, each winner drops req one cycle after its grant -> grants 0001, 0010, 0100, 1000, 0001; grant_idx 0,1,2,3,0; no cycle with grant_valid low.
- req=4'b0100 held 10 cycles with other bits 0 -> grant=0100 and grant_idx=2 for all 10 cycles. Then req=0 -> grant=0 and grant_valid=0 one cycle later.
- Grant held on ch3 (ptr=3), then req=4'b0011 and ch3 releases -> next grant is 0001 (wrap from 3 to 0), not 0010.
- rst pulsed high for one cycle while ch2 is granted with req=4'b1111 -> outputs 0 after that edge. With rst low, the first grant is 0001.
- Timeout build, req=4'b0011 held constant -> ch0 granted 4 cycles, then ch1 for 4 cycles, alternating. Non-timeout build with the same stimulus -> ch0 granted indefinitely.
- Timeout build, req=4'b0001 only for 20 cycles -> ch0 keeps the grant throughout; no deassert glitch.
